// File: rtl/scv_cartridge.sv
// Super Cassette Vision cartridge slot: 128 KiB init-loaded ROM, optional 8 KiB
// work RAM, mapper-driven decode of the CPU upper 32 KiB window.
module scv_cartridge (
  input  logic        CLK,
  input  logic        RESB,
  input  logic        INIT_SEL,
  input  logic [16:0] INIT_ADDR,
  input  logic [7:0]  INIT_DATA,
  input  logic        INIT_VALID,
  input  logic [2:0]  MAPPER,
  input  logic [14:0] A,
  input  logic [7:0]  DB_I,
  output logic [7:0]  DB_O,
  output logic        DB_OE,
  input  logic        CSB,
  input  logic        RDB,
  input  logic        WRB,
  input  logic [1:0]  PC
);

  localparam int unsigned ROM_AW = 17;
  localparam int unsigned RAM_AW = 13;
  localparam int unsigned DW     = 8;
  localparam int unsigned ROM_DEPTH = 1 << ROM_AW;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

  typedef enum logic [2:0] {
    ROM8K        = 3'd0,
    ROM16K       = 3'd1,
    ROM32K       = 3'd2,
    ROM32K_RAM8K = 3'd3,
    ROM64K       = 3'd4,
    ROM128K      = 3'd5,
    RSVD6        = 3'd6,
    RSVD7        = 3'd7
  } mapper_t;

  logic [DW-1:0]     rom_mem [ROM_DEPTH];
  logic [DW-1:0]     ram_mem [RAM_DEPTH];

  mapper_t           mapper;
  logic [ROM_AW-1:0] rom_addr;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_region;
  logic              ram_we;
  logic              init_we;
  logic [DW-1:0]     rd_d;
  logic [DW-1:0]     rd_q;

  assign mapper = mapper_t'(MAPPER);

  // Window-to-ROM address translation; reserved codes fall back to plain 32 KiB.
  always_comb begin
    rom_addr = {2'b00, A};
    unique case (mapper)
      ROM8K:   rom_addr = {4'b0000, A[12:0]};
      ROM16K:  rom_addr = {3'b000, A[13:0]};
      ROM64K:  rom_addr = {1'b0, PC[0], A};
      ROM128K: rom_addr = {PC[1], PC[0], A};
      default: rom_addr = {2'b00, A};
    endcase
  end

  assign ram_addr   = A[12:0];
  assign ram_region = (mapper == ROM32K_RAM8K) && (A[14:13] == 2'b11);
  assign ram_we     = RESB && !CSB && !WRB && ram_region;
  assign init_we    = RESB && INIT_SEL && INIT_VALID;

  assign DB_OE = !CSB && !RDB;

  always_ff @(posedge CLK) begin
    if (init_we) begin
      rom_mem[INIT_ADDR] <= INIT_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= DB_I;
    end
  end

  // Write-first on the RAM port: a byte written this cycle appears on DB_O next cycle.
  always_comb begin
    rd_d = rom_mem[rom_addr];
    if (ram_region) begin
      rd_d = ram_we ? DB_I : ram_mem[ram_addr];
    end
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign DB_O = rd_q;

endmodule

// File: tb/tb_scv_cartridge.sv
// Scoreboard bench for scv_cartridge: stimulus queues expected bus values,
// a negedge monitor pops and compares them against DB_O / DB_OE.
module tb_scv_cartridge;

  logic        CLK = 1'b0;
  logic        RESB;
  logic        INIT_SEL;
  logic [16:0] INIT_ADDR;
  logic [7:0]  INIT_DATA;
  logic        INIT_VALID;
  logic [2:0]  MAPPER;
  logic [14:0] A;
  logic [7:0]  DB_I;
  logic [7:0]  DB_O;
  logic        DB_OE;
  logic        CSB;
  logic        RDB;
  logic        WRB;
  logic [1:0]  PC;

  scv_cartridge dut (
    .CLK(CLK), .RESB(RESB), .INIT_SEL(INIT_SEL), .INIT_ADDR(INIT_ADDR),
    .INIT_DATA(INIT_DATA), .INIT_VALID(INIT_VALID), .MAPPER(MAPPER), .A(A),
    .DB_I(DB_I), .DB_O(DB_O), .DB_OE(DB_OE), .CSB(CSB), .RDB(RDB), .WRB(WRB),
    .PC(PC)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       chk_data;
    logic [7:0] data;
    logic       oe;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if ((e.chk_data && DB_O !== e.data) || DB_OE !== e.oe) begin
        failures++;
        $display("FAIL %s: DB_O=%02h DB_OE=%0b, required DB_O=%02h(chk=%0b) DB_OE=%0b",
                 n, DB_O, DB_OE, e.data, e.chk_data, e.oe);
      end
    end
  end

  task automatic expect_bus(input string n, input logic chk, input logic [7:0] d, input logic oe);
    exp_t e;
    e.chk_data = chk;
    e.data     = d;
    e.oe       = oe;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic init_byte(input logic [16:0] addr, input logic [7:0] d);
    @(posedge CLK); #1;
    INIT_SEL = 1'b1; INIT_VALID = 1'b1; INIT_ADDR = addr; INIT_DATA = d;
    @(posedge CLK); #1;
    INIT_SEL = 1'b0; INIT_VALID = 1'b0;
  endtask

  task automatic rd(input string n, input logic [2:0] m, input logic [14:0] a,
                    input logic [1:0] pc, input logic csb, input logic rdb,
                    input logic [7:0] exp_d, input logic exp_oe);
    @(posedge CLK); #1;
    MAPPER = m; A = a; PC = pc; CSB = csb; RDB = rdb; WRB = 1'b1;
    @(posedge CLK); #1;
    expect_bus(n, 1'b1, exp_d, exp_oe);
  endtask

  // One-cycle write pulse; exp_d is what DB_O shows right after the write edge.
  task automatic wr(input string n, input logic [2:0] m, input logic [14:0] a,
                    input logic csb, input logic [7:0] d, input logic [7:0] exp_d);
    @(posedge CLK); #1;
    MAPPER = m; A = a; PC = 2'd0; CSB = csb; RDB = 1'b1; WRB = 1'b0; DB_I = d;
    @(posedge CLK); #1;
    expect_bus(n, 1'b1, exp_d, 1'b0);
    WRB = 1'b1;
  endtask

  initial begin
    RESB = 1'b0; INIT_SEL = 1'b0; INIT_ADDR = '0; INIT_DATA = '0; INIT_VALID = 1'b0;
    MAPPER = 3'd2; A = '0; DB_I = '0; CSB = 1'b1; RDB = 1'b1; WRB = 1'b1; PC = '0;
    #2;
    expect_bus("reset_state", 1'b1, 8'h00, 1'b0);
    repeat (3) @(posedge CLK);
    #1 RESB = 1'b1;

    init_byte(17'h00000, 8'h11);
    init_byte(17'h07FFF, 8'h22);
    init_byte(17'h05FFF, 8'h33);
    init_byte(17'h06010, 8'h44);
    init_byte(17'h00123, 8'h5A);
    init_byte(17'h02123, 8'hEE);
    init_byte(17'h06123, 8'hE6);
    init_byte(17'h08000, 8'hA1);
    init_byte(17'h10000, 8'hB2);
    init_byte(17'h18000, 8'hC3);

    rd("rom32k_a0000",   3'd2, 15'h0000, 2'd0, 1'b0, 1'b0, 8'h11, 1'b1);
    rd("rom32k_a7fff",   3'd2, 15'h7FFF, 2'd0, 1'b0, 1'b0, 8'h22, 1'b1);
    rd("rom32k_rdb_hi",  3'd2, 15'h7FFF, 2'd0, 1'b0, 1'b1, 8'h22, 1'b0);
    rd("rsvd7_as_32k",   3'd7, 15'h2123, 2'd3, 1'b0, 1'b0, 8'hEE, 1'b1);

    rd("rom8k_0123",     3'd0, 15'h0123, 2'd0, 1'b0, 1'b0, 8'h5A, 1'b1);
    rd("rom8k_2123",     3'd0, 15'h2123, 2'd0, 1'b0, 1'b0, 8'h5A, 1'b1);
    rd("rom8k_4123",     3'd0, 15'h4123, 2'd0, 1'b0, 1'b0, 8'h5A, 1'b1);
    rd("rom8k_6123",     3'd0, 15'h6123, 2'd0, 1'b0, 1'b0, 8'h5A, 1'b1);
    rd("rom16k_6123",    3'd1, 15'h6123, 2'd0, 1'b0, 1'b0, 8'hEE, 1'b1);

    rd("rom128k_pc0",    3'd5, 15'h0000, 2'd0, 1'b0, 1'b0, 8'h11, 1'b1);
    rd("rom128k_pc1",    3'd5, 15'h0000, 2'd1, 1'b0, 1'b0, 8'hA1, 1'b1);
    rd("rom128k_pc2",    3'd5, 15'h0000, 2'd2, 1'b0, 1'b0, 8'hB2, 1'b1);
    rd("rom128k_pc3",    3'd5, 15'h0000, 2'd3, 1'b0, 1'b0, 8'hC3, 1'b1);
    rd("rom64k_pc3",     3'd4, 15'h0000, 2'd3, 1'b0, 1'b0, 8'hA1, 1'b1);
    rd("rom64k_pc2",     3'd4, 15'h0000, 2'd2, 1'b0, 1'b0, 8'h11, 1'b1);

    wr("ram_wr_first",   3'd3, 15'h6010, 1'b0, 8'h77, 8'h77);
    rd("ram_rd_6010",    3'd3, 15'h6010, 2'd0, 1'b0, 1'b0, 8'h77, 1'b1);
    rd("ram_map_5fff",   3'd3, 15'h5FFF, 2'd0, 1'b0, 1'b0, 8'h33, 1'b1);
    wr("rom32k_wr_ign",  3'd2, 15'h6010, 1'b0, 8'h55, 8'h44);
    rd("rom32k_rd_6010", 3'd2, 15'h6010, 2'd0, 1'b0, 1'b0, 8'h44, 1'b1);
    rd("ram_kept_77",    3'd3, 15'h6010, 2'd0, 1'b0, 1'b0, 8'h77, 1'b1);

    rd("csb_hi_no_oe",   3'd3, 15'h6010, 2'd0, 1'b1, 1'b0, 8'h77, 1'b0);
    wr("csb_hi_wr",      3'd3, 15'h6010, 1'b1, 8'h99, 8'h77);
    rd("csb_hi_ram_77",  3'd3, 15'h6010, 2'd0, 1'b0, 1'b0, 8'h77, 1'b1);

    // Reset mid-read, with a suppressed init attempt while held.
    @(posedge CLK); #1;
    RESB = 1'b0;
    #1 expect_bus("reset_async", 1'b1, 8'h00, 1'b1);
    @(negedge CLK); #1;
    INIT_SEL = 1'b1; INIT_VALID = 1'b1; INIT_ADDR = 17'h00000; INIT_DATA = 8'hFF;
    @(posedge CLK); #1;
    INIT_SEL = 1'b0; INIT_VALID = 1'b0;
    RESB = 1'b1;
    @(posedge CLK); #1;
    expect_bus("reset_release", 1'b1, 8'h77, 1'b1);
    rd("rom_kept_0000",  3'd2, 15'h0000, 2'd0, 1'b0, 1'b0, 8'h11, 1'b1);
    rd("rom_kept_7fff",  3'd2, 15'h7FFF, 2'd0, 1'b0, 1'b0, 8'h22, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    @(posedge CLK);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
